btn_debounce_oneshot: RTL and testbench
=======================================

BTN_DEBOUNCE_ONESHOT -- requirements
Module: btn_debounce_oneshot

Interface
REQ-001 Parameter DB_COUNT, default 500000: consecutive stable synchronized cycles required to accept a level change; legal range 2..2^24-1.
REQ-002 Parameter COUNT_W, default 16: width of press counter.
REQ-003 CLK  input  1  system clock (50 MHz CPU clock domain); all state on rising edge.
REQ-004 RST  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 BTN_IN  input  1  raw board pushbutton, asynchronous to CLK, bouncy.
REQ-006 CLR_COUNT  input  1  synchronous clear of press counter (driven by an IOBUS write decode).
REQ-007 BTN_LEVEL  output  1  debounced button level.
REQ-008 BTN_PULSE  output  1  single-cycle strobe on accepted press (interrupt source).
REQ-009 BTN_COUNT  output  COUNT_W  number of accepted presses, read back on IOBUS_in.

Function
REQ-010 BTN_IN shall pass through a 2-flop synchronizer; only synchronizer output S feeds the FSM.
REQ-011 FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW; 24-bit stability counter CNT.
REQ-012 LOW: S=1 -> WAIT_HIGH with CNT<=0; else stay.
REQ-013 WAIT_HIGH: S=0 -> LOW (bounce rejected, no pulse); S=1 and CNT=DB_COUNT-1 -> HIGH; else CNT<=CNT+1.
REQ-014 HIGH: S=0 -> WAIT_LOW with CNT<=0; else stay.
REQ-015 WAIT_LOW: S=1 -> HIGH (bounce rejected); S=0 and CNT=DB_COUNT-1 -> LOW; else CNT<=CNT+1.
REQ-016 BTN_LEVEL shall be 1 in HIGH and WAIT_LOW, 0 in LOW and WAIT_HIGH; registered, no combinational path from BTN_IN.
REQ-017 Latency: with BTN_IN stable after a change, BTN_LEVEL shall change on the (DB_COUNT+3)th CLK rising edge after the change.
REQ-018 BTN_PULSE shall be 1 for exactly the first cycle of HIGH entered from WAIT_HIGH; never on release, never on WAIT_LOW->HIGH bounce return.
REQ-019 BTN_COUNT shall increment by 1 in the same edge that asserts BTN_PULSE; wraps from 2^COUNT_W-1 to 0, no saturation.
REQ-020 CLR_COUNT=1 shall set BTN_COUNT to 0 on the next edge; clear has priority when coincident with a press increment (result 0).
REQ-021 CLR_COUNT shall not affect FSM, CNT, BTN_LEVEL, or BTN_PULSE.
REQ-022 A held button shall produce exactly one pulse regardless of hold duration.

Reset
REQ-023 RST=1 shall immediately force state LOW, CNT=0, synchronizer flops 0, BTN_LEVEL=0, BTN_PULSE=0, BTN_COUNT=0, independent of CLK.
REQ-024 Reset asserted mid-debounce shall abort the pending transition; no pulse shall be emitted for it.
REQ-025 Button held through reset release shall be treated as a new press: BTN_LEVEL=1 and one BTN_PULSE after DB_COUNT+3 edges.

Verification (DB_COUNT=4, COUNT_W=4)
REQ-026 Clean press: BTN_IN 0->1 held -> BTN_LEVEL=1 and BTN_PULSE=1 on edge 7, BTN_PULSE=0 on edge 8, BTN_COUNT=1.
REQ-027 Bounce: BTN_IN high 3 cycles, low 1, high held -> no pulse before restart; single pulse 7 edges after final rise; BTN_COUNT=1.
REQ-028 Release bounce: from HIGH, BTN_IN low 2 cycles then high -> BTN_LEVEL stays 1, no pulse, BTN_COUNT unchanged.
REQ-029 Wrap and clear: 16 clean presses -> BTN_COUNT=0; 17th press with CLR_COUNT=1 on its pulse edge -> BTN_COUNT=0, BTN_PULSE still 1.
REQ-030 Reset mid-debounce: RST pulse at edge 5 of a press, BTN_IN held -> all outputs 0 during RST; one pulse 7 edges after RST deassert; BTN_COUNT=1.

Source files
------------

// File: rtl/btn_debounce_oneshot.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce FSM,
// one-shot press strobe and wrapping press counter.
module btn_debounce_oneshot #(
  parameter int unsigned DB_COUNT = 500000,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               BTN_IN,
  input  logic               CLR_COUNT,
  output logic               BTN_LEVEL,
  output logic               BTN_PULSE,
  output logic [COUNT_W-1:0] BTN_COUNT
);

  typedef enum logic [1:0] {
    LOW,
    WAIT_HIGH,
    HIGH,
    WAIT_LOW
  } state_e;

  localparam logic [23:0] CNT_END = 24'(DB_COUNT - 1);

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  state_e             state_q, state_d;
  logic [23:0]        cnt_q, cnt_d;
  logic               level_q, level_d;
  logic               pulse_q, pulse_d;
  logic [COUNT_W-1:0] count_q, count_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    sync1_d = BTN_IN;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOW: begin
        if (sync2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2_q)
          state_d = LOW;
        else if (cnt_q == CNT_END)
          state_d = HIGH;
        else
          cnt_d = cnt_q + 24'd1;
      end
      HIGH: begin
        if (!sync2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2_q)
          state_d = HIGH;
        else if (cnt_q == CNT_END)
          state_d = LOW;
        else
          cnt_d = cnt_q + 24'd1;
      end
    endcase
  end

  // Outputs are registered from the next state so they move on the
  // same edge as the state change itself.
  always_comb begin
    level_d = (state_d == HIGH) || (state_d == WAIT_LOW);
    pulse_d = (state_q == WAIT_HIGH) && (state_d == HIGH);
    count_d = count_q;
    if (CLR_COUNT)
      count_d = '0;
    else if (pulse_d)
      count_d = count_q + COUNT_W'(1);
  end

  assign BTN_LEVEL = level_q;
  assign BTN_PULSE = pulse_q;
  assign BTN_COUNT = count_q;

endmodule

// File: tb/tb_btn_debounce_oneshot.sv
// Scoreboard bench for btn_debounce_oneshot with DB_COUNT=4,
// COUNT_W=4: expected pulses are queued with cycle and count.
module tb_btn_debounce_oneshot;

  localparam int DB = 4;
  localparam int CW = 4;
  localparam int LAT = DB + 3;

  typedef struct {
    int          cyc;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn;
  logic          clr;
  logic          level;
  logic          pulse;
  logic [CW-1:0] count;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  btn_debounce_oneshot #(
    .DB_COUNT(DB),
    .COUNT_W (CW)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .BTN_IN   (btn),
    .CLR_COUNT(clr),
    .BTN_LEVEL(level),
    .BTN_PULSE(pulse),
    .BTN_COUNT(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (pulse === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse cycle=%0d count=%0d",
                 cyc, count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cyc !== e.cyc || count !== e.cnt || level !== 1'b1) begin
          n_fail++;
          $display("FAIL pulse cycle=%0d count=%0d level=%b exp cycle=%0d count=%0d level=1",
                   cyc, count, level, e.cyc, e.cnt);
        end
      end
    end
  end

  task automatic push_press(input logic [CW-1:0] c);
    exp_t e;
    e.cyc = cyc + LAT;
    e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing_pulse pending=%0d exp=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn = 1'b0;
    clr = 1'b0;
    #1;
    n_checks++;
    if (level !== 1'b0 || pulse !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL do_reset level=%b pulse=%b count=%0d exp 0/0/0",
               level, pulse, count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (level !== 1'b0 || pulse !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL reset_async level=%b pulse=%b count=%0d exp 0/0/0",
               level, pulse, count);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (level !== 1'b0 || pulse !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL reset_held level=%b pulse=%b count=%0d exp 0/0/0",
               level, pulse, count);
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    do_reset();
    @(negedge clk);
    btn = 1'b1;
    push_press(CW'(1));
    repeat (LAT - 1) @(negedge clk);
    n_checks++;
    if (level !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_early level=%b exp 0", level);
    end
    @(negedge clk);
    n_checks++;
    if (level !== 1'b1 || pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_edge7 level=%b pulse=%b exp 1/1", level, pulse);
    end
    @(negedge clk);
    n_checks++;
    if (pulse !== 1'b0 || count !== CW'(1)) begin
      n_fail++;
      $display("FAIL clean_edge8 pulse=%b count=%0d exp 0/1", pulse, count);
    end
    repeat (30) @(negedge clk);
    btn = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    n_checks++;
    if (level !== 1'b1) begin
      n_fail++;
      $display("FAIL release_early level=%b exp 1", level);
    end
    @(negedge clk);
    n_checks++;
    if (level !== 1'b0 || count !== CW'(1)) begin
      n_fail++;
      $display("FAIL release level=%b count=%0d exp 0/1", level, count);
    end
    drain("clean");
  endtask

  task automatic test_bounce();
    do_reset();
    @(negedge clk);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    @(negedge clk);
    btn = 1'b1;
    push_press(CW'(1));
    repeat (LAT - 1) @(negedge clk);
    n_checks++;
    if (level !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL bounce_early level=%b count=%0d exp 0/0", level, count);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (level !== 1'b1 || count !== CW'(1)) begin
      n_fail++;
      $display("FAIL bounce_final level=%b count=%0d exp 1/1", level, count);
    end
    drain("bounce");
  endtask

  task automatic test_release_bounce();
    btn = 1'b0;
    repeat (2) @(negedge clk);
    btn = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++;
    if (level !== 1'b1 || count !== CW'(1)) begin
      n_fail++;
      $display("FAIL relbounce level=%b count=%0d exp 1/1", level, count);
    end
    drain("relbounce");
  endtask

  task automatic test_reset_mid();
    btn = 1'b0;
    repeat (10) @(negedge clk);
    btn = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (level !== 1'b0 || pulse !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL rstmid_during level=%b pulse=%b count=%0d exp 0/0/0",
               level, pulse, count);
    end
    @(negedge clk);
    rst = 1'b0;
    push_press(CW'(1));
    repeat (LAT - 1) @(negedge clk);
    n_checks++;
    if (level !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_early level=%b exp 0", level);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (level !== 1'b1 || count !== CW'(1)) begin
      n_fail++;
      $display("FAIL rstmid_final level=%b count=%0d exp 1/1", level, count);
    end
    drain("rstmid");
  endtask

  task automatic test_wrap_clear();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      btn = 1'b1;
      push_press(CW'(i));
      repeat (LAT + 1) @(negedge clk);
      btn = 1'b0;
      repeat (LAT + 1) @(negedge clk);
    end
    n_checks++;
    if (count !== '0) begin
      n_fail++;
      $display("FAIL wrap count=%0d exp 0", count);
    end
    @(negedge clk);
    btn = 1'b1;
    push_press('0);
    repeat (LAT - 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if (pulse !== 1'b1 || count !== '0 || level !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_coincident pulse=%b count=%0d level=%b exp 1/0/1",
               pulse, count, level);
    end
    drain("wrap");
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    clr = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_reset_mid();
    test_wrap_clear();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
